// File: rtl/ysyx_24080006_icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package ysyx_24080006_icache_pkg;

  localparam int IC_WAYS       = 2;
  localparam int IC_SETS       = 16;
  localparam int IC_LINE_WORDS = 4;

  // Tag is held zero-extended to 32 bits so one struct serves every geometry;
  // the unused upper bits are constant and fold away in synthesis.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
  } icache_meta_t;

  typedef enum logic [2:0] {
    IC_IDLE,
    IC_LOOKUP,
    IC_MISS_AR,
    IC_MISS_R,
    IC_RESP
  } icache_state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int ic_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_24080006_icache_way.sv
// One cache way: per-set metadata plus LINE_WORDS data words per set.
// Combinational read of the addressed set/word, one-word-per-cycle fill write.
module ysyx_24080006_icache_way
  import ysyx_24080006_icache_pkg::*;
#(
  parameter int SETS       = IC_SETS,
  parameter int LINE_WORDS = IC_LINE_WORDS,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WORD_W    = ic_clog2_min1(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [31:0]       rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              meta_we,
  input  logic              meta_valid,
  input  logic [31:0]       meta_tag,
  input  logic              inv_all
);

  icache_meta_t meta_reg [SETS];
  logic [31:0]  data_reg [SETS][LINE_WORDS];

  assign rd_valid = meta_reg[idx].valid;
  assign rd_tag   = meta_reg[idx].tag;
  assign rd_data  = data_reg[idx][rd_word];

  // Metadata: invalidate-all wins over a tag write landing in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) meta_reg[s] <= '0;
    end else if (inv_all) begin
      for (int s = 0; s < SETS; s++) meta_reg[s].valid <= 1'b0;
    end else if (meta_we) begin
      meta_reg[idx] <= {meta_valid, meta_tag};
    end
  end

  // Data words: written one beat at a time during a line fill.
  always_ff @(posedge clock) begin
    if (wr_en) data_reg[idx][wr_word] <= wr_data;
  end

endmodule

// File: rtl/ysyx_24080006_icache_sa.sv
// Set-associative multi-word-line instruction cache between the IFU fetch port
// and an AXI4 read channel. 1-cycle hits, INCR-burst line fills, fence.i flush.
module ysyx_24080006_icache_sa
  import ysyx_24080006_icache_pkg::*;
#(
  parameter int WAYS       = IC_WAYS,
  parameter int SETS       = IC_SETS,
  parameter int LINE_WORDS = IC_LINE_WORDS
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        flush,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  output logic [7:0]  mem_arlen,
  output logic [2:0]  mem_arsize,
  output logic [1:0]  mem_arburst,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rlast,
  output logic        perf_hit,
  output logic        perf_miss
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WORD_W = ic_clog2_min1(LINE_WORDS);
  localparam int WAY_W  = ic_clog2_min1(WAYS);

  icache_state_e     state_reg, state_next;
  logic [31:2]       addr_reg;
  logic [WAY_W-1:0]  victim_reg;
  logic [WORD_W-1:0] beat_reg;
  logic              err_reg;
  logic              flush_pend_reg;
  logic              first_reg;
  logic [31:0]       word_reg;
  logic [WAY_W-1:0]  rr_reg [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] word_sel;

  assign idx = addr_reg[IDX_W+OFF_W-1:OFF_W];
  assign tag = addr_reg[31:IDX_W+OFF_W];

  if (LINE_WORDS > 1) begin : g_word
    assign word_sel = addr_reg[OFF_W-1:2];
  end else begin : g_word_single
    assign word_sel = '0;
  end

  // Lookup / fill wiring shared by every way
  logic              way_valid [WAYS];
  logic [31:0]       way_tag   [WAYS];
  logic [31:0]       way_data  [WAYS];
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [31:0]       hit_data;
  logic [WAY_W-1:0]  victim_sel;
  logic              fill_beat, beat_last, fill_done, err_now;
  logic              meta_valid, inv_all, accept, leave_to_idle;

  assign fill_beat = (state_reg == IC_MISS_R) && mem_rvalid;
  assign beat_last = (beat_reg == WORD_W'(LINE_WORDS - 1));
  assign fill_done = fill_beat && beat_last;
  assign err_now   = err_reg || (mem_rresp != 2'b00) || (mem_rlast != beat_last);
  // A fill is only trusted when the burst was clean and no fence.i overlapped it.
  assign meta_valid = !err_now && !flush_pend_reg && !flush;
  assign accept     = req_valid && req_ready;
  assign leave_to_idle = (state_reg != IC_IDLE) && (state_next == IC_IDLE);
  assign inv_all    = ((state_reg == IC_IDLE) && flush) ||
                      (leave_to_idle && (flush_pend_reg || flush));

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    ysyx_24080006_icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clock      (clock),
      .rst_n      (rst_n),
      .idx        (idx),
      .rd_word    (word_sel),
      .rd_valid   (way_valid[gi]),
      .rd_tag     (way_tag[gi]),
      .rd_data    (way_data[gi]),
      .wr_en      (fill_beat && (victim_reg == WAY_W'(gi))),
      .wr_word    (beat_reg),
      .wr_data    (mem_rdata),
      .meta_we    (fill_done && (victim_reg == WAY_W'(gi))),
      .meta_valid (meta_valid),
      .meta_tag   (32'(tag)),
      .inv_all    (inv_all)
    );
    assign hit_vec[gi] = way_valid[gi] && (way_tag[gi] == 32'(tag));
  end

  assign hit = |hit_vec;

  // Hit data mux and victim choice: first invalid way, else round-robin pointer
  always_comb begin
    logic found;
    hit_data   = '0;
    victim_sel = rr_reg[idx];
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_data = hit_data | way_data[w];
      if (!found && !way_valid[w]) begin
        victim_sel = WAY_W'(w);
        found      = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IC_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IC_IDLE:    if (accept) state_next = IC_LOOKUP;
      IC_LOOKUP: begin
        if (!hit)           state_next = IC_MISS_AR;
        else if (rsp_ready) state_next = accept ? IC_LOOKUP : IC_IDLE;
      end
      IC_MISS_AR: if (mem_arready) state_next = IC_MISS_R;
      IC_MISS_R:  if (fill_done)   state_next = IC_RESP;
      IC_RESP:    if (rsp_ready)   state_next = IC_IDLE;
      default:    state_next = IC_IDLE;
    endcase
  end

  // Outputs decoded from state; back-to-back hits are blocked while a flush waits
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_inst    = '0;
    rsp_err     = 1'b0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    perf_hit    = 1'b0;
    perf_miss   = 1'b0;
    case (state_reg)
      IC_IDLE: req_ready = !flush;
      IC_LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          rsp_inst  = hit_data;
          perf_hit  = first_reg;
          req_ready = rsp_ready && !flush && !flush_pend_reg;
        end else begin
          perf_miss = 1'b1;
        end
      end
      IC_MISS_AR: mem_arvalid = 1'b1;
      IC_MISS_R:  mem_rready  = 1'b1;
      IC_RESP: begin
        rsp_valid = 1'b1;
        rsp_inst  = word_reg;
        rsp_err   = err_reg;
      end
      default: ;
    endcase
  end

  assign mem_araddr  = {addr_reg[31:OFF_W], {OFF_W{1'b0}}};
  assign mem_arlen   = 8'(LINE_WORDS - 1);
  assign mem_arsize  = 3'b010;
  assign mem_arburst = 2'b01;

  // Request latch, fill bookkeeping, flush tracking and round-robin pointers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      victim_reg     <= '0;
      beat_reg       <= '0;
      err_reg        <= 1'b0;
      flush_pend_reg <= 1'b0;
      first_reg      <= 1'b0;
      word_reg       <= '0;
      for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
    end else begin
      first_reg <= accept;
      if (accept) addr_reg <= req_addr[31:2];
      if ((state_reg == IC_LOOKUP) && !hit) begin
        victim_reg <= victim_sel;
        beat_reg   <= '0;
        err_reg    <= 1'b0;
      end
      if (fill_beat) begin
        beat_reg <= beat_reg + 1'b1;
        err_reg  <= err_now;
        if (beat_reg == word_sel) word_reg <= mem_rdata;
      end
      if (fill_done) begin
        rr_reg[idx] <= (rr_reg[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[idx] + 1'b1;
      end
      if (leave_to_idle)                      flush_pend_reg <= 1'b0;
      else if (flush && state_reg != IC_IDLE) flush_pend_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_icache_sa.sv
// Directed bench for the set-associative icache with a zero-wait AXI read slave.
module tb_ysyx_24080006_icache_sa;

  logic        clock, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err, flush;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rlast;
  logic        perf_hit, perf_miss;

  int n_cmp = 0;
  int n_fail = 0;

  ysyx_24080006_icache_sa dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .flush(flush),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Backing memory contents: the first line holds 0x11..0x44, elsewhere addr^0xC0DE0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h11;
      32'h8000_0004: return 32'h22;
      32'h8000_0008: return 32'h33;
      32'h8000_000C: return 32'h44;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Zero-wait AXI read slave; err_beat selects a beat answered with SLVERR
  logic        s_busy;
  logic [31:0] s_addr;
  int          s_beat;
  int          err_beat = -1;

  assign mem_arready = !s_busy;
  assign mem_rvalid  = s_busy;
  assign mem_rdata   = mem_word(s_addr + 32'(s_beat * 4));
  assign mem_rresp   = (s_beat == err_beat) ? 2'b10 : 2'b00;
  assign mem_rlast   = (s_beat == 3);

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_busy <= 1'b0;
      s_addr <= '0;
      s_beat <= 0;
    end else if (!s_busy) begin
      if (mem_arvalid) begin
        s_busy <= 1'b1;
        s_addr <= mem_araddr;
        s_beat <= 0;
      end
    end else if (mem_rready) begin
      if (s_beat == 3) s_busy <= 1'b0;
      s_beat <= s_beat + 1;
    end
  end

  logic [31:0] obs_araddr;
  logic [7:0]  obs_arlen;
  logic [2:0]  obs_arsize;
  logic [1:0]  obs_arburst;

  // Issue one fetch from IDLE and wait (bounded) for its response; lat=-1 on timeout
  task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output logic err,
                       output int lat, output logic saw_hit, output logic saw_miss);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1; saw_hit = 1'b0; saw_miss = 1'b0;
    while (!rsp_valid && lat < 50) begin
      saw_hit |= perf_hit; saw_miss |= perf_miss;
      if (mem_arvalid) begin
        obs_araddr = mem_araddr; obs_arlen = mem_arlen;
        obs_arsize = mem_arsize; obs_arburst = mem_arburst;
      end
      @(negedge clock);
      lat++;
    end
    saw_hit |= perf_hit; saw_miss |= perf_miss;
    inst = rsp_inst; err = rsp_err;
    if (!rsp_valid) lat = -1;
    $display("fetch addr=%h inst=%h err=%0d lat=%0d hit=%0d miss=%0d", a, inst, err, lat, saw_hit, saw_miss);
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, mem_arvalid, mem_rready, perf_hit, perf_miss} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000", {rsp_valid, rsp_err, mem_arvalid, mem_rready, perf_hit, perf_miss}); end
    n_cmp++; if (mem_araddr !== 32'h0 || rsp_inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got araddr=%h inst=%h want 0/0", mem_araddr, rsp_inst); end
    rst_n = 1'b1;
    @(negedge clock);
    $display("reset released");
  endtask

  task automatic test_cold_miss();
    logic [31:0] inst; logic err, h, m; int lat;
    fetch(32'h8000_0008, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h33 || lat !== 7) begin n_fail++; $display("FAIL cold_miss got inst=%h lat=%0d want 33/7", inst, lat); end
    n_cmp++; if (m !== 1'b1 || h !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL cold_miss_flags got miss=%b hit=%b err=%b want 1/0/0", m, h, err); end
    n_cmp++; if (obs_araddr !== 32'h8000_0000 || obs_arlen !== 8'd3) begin n_fail++; $display("FAIL cold_ar got addr=%h len=%0d want 80000000/3", obs_araddr, obs_arlen); end
    n_cmp++; if (obs_arsize !== 3'b010 || obs_arburst !== 2'b01) begin n_fail++; $display("FAIL cold_ar_fixed got size=%b burst=%b want 010/01", obs_arsize, obs_arburst); end
    fetch(32'h8000_000C, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h44 || lat !== 1 || h !== 1'b1 || m !== 1'b0) begin
      n_fail++; $display("FAIL refetch_hit got inst=%h lat=%0d hit=%b miss=%b want 44/1/1/0", inst, lat, h, m); end
  endtask

  task automatic test_eviction();
    logic [31:0] inst; logic err, h, m; int lat;
    fetch(32'h8000_0404, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h40DE_0404 || m !== 1'b1) begin n_fail++; $display("FAIL fill_way1 got inst=%h miss=%b want 40de0404/1", inst, m); end
    fetch(32'h8000_0800, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h40DE_0800 || m !== 1'b1) begin n_fail++; $display("FAIL fill_third got inst=%h miss=%b want 40de0800/1", inst, m); end
    fetch(32'h8000_0400, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h40DE_0400 || h !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL survivor_hit got inst=%h hit=%b lat=%0d want 40de0400/1/1", inst, h, lat); end
    fetch(32'h8000_0000, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h11 || m !== 1'b1 || lat !== 7) begin n_fail++; $display("FAIL evicted_miss got inst=%h miss=%b lat=%0d want 11/1/7", inst, m, lat); end
    fetch(32'h8000_0808, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h40DE_0808 || h !== 1'b1) begin n_fail++; $display("FAIL rr_keeps_way0 got inst=%h hit=%b want 40de0808/1", inst, h); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst, held; logic err, h, m; int lat;
    fetch(32'h8000_0010, inst, err, lat, h, m);
    n_cmp++; if (inst !== 32'h40DE_0010 || m !== 1'b1) begin n_fail++; $display("FAIL b2b_fill got inst=%h miss=%b want 40de0010/1", inst, m); end
    req_valid = 1'b1; req_addr = 32'h8000_0010; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      $display("b2b beat %0d valid=%b inst=%h hit=%b", i, rsp_valid, rsp_inst, perf_hit);
      n_cmp++;
      if (rsp_valid !== 1'b1 || perf_hit !== 1'b1 || rsp_inst !== mem_word(32'h8000_0010 + 32'(4 * i))) begin
        n_fail++; $display("FAIL b2b_%0d got valid=%b hit=%b inst=%h want 1/1/%h", i, rsp_valid, perf_hit, rsp_inst, mem_word(32'h8000_0010 + 32'(4 * i))); end
      if (i < 3) req_addr = 32'h8000_0014 + 32'(4 * i);
      else req_valid = 1'b0;
    end
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8000_0014;
    @(negedge clock);
    req_valid = 1'b0;
    held = rsp_inst;
    n_cmp++; if (rsp_valid !== 1'b1 || held !== 32'h40DE_0014 || perf_hit !== 1'b1) begin
      n_fail++; $display("FAIL stall_first got valid=%b inst=%h hit=%b want 1/40de0014/1", rsp_valid, held, perf_hit); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      $display("stall cycle %0d valid=%b inst=%h hit=%b", i, rsp_valid, rsp_inst, perf_hit);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h40DE_0014 || perf_hit !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d got valid=%b inst=%h hit=%b want 1/40de0014/0", i, rsp_valid, rsp_inst, perf_hit); end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_error();
    logic [31:0] inst; logic err, h, m; int lat;
    err_beat = 1;
    fetch(32'h8000_0028, inst, err, lat, h, m);
    err_beat = -1;
    n_cmp++; if (err !== 1'b1 || inst !== 32'h40DE_0028 || lat !== 7) begin
      n_fail++; $display("FAIL err_resp got err=%b inst=%h lat=%0d want 1/40de0028/7", err, inst, lat); end
    fetch(32'h8000_002C, inst, err, lat, h, m);
    n_cmp++; if (m !== 1'b1 || err !== 1'b0 || inst !== 32'h40DE_002C) begin
      n_fail++; $display("FAIL err_not_valid got miss=%b err=%b inst=%h want 1/0/40de002c", m, err, inst); end
  endtask

  task automatic test_flush();
    logic [31:0] inst; logic err, h, m; int lat, k;
    req_valid = 1'b1; req_addr = 32'h8000_0030; rsp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (!mem_rready && k < 20) begin @(negedge clock); k++; end
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clock); k++; end
    $display("flush_in_fill rsp valid=%b inst=%h err=%b", rsp_valid, rsp_inst, rsp_err);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h40DE_0030 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_resp got valid=%b inst=%h err=%b want 1/40de0030/0", rsp_valid, rsp_inst, rsp_err); end
    @(negedge clock);
    fetch(32'h8000_0030, inst, err, lat, h, m);
    n_cmp++; if (m !== 1'b1 || lat !== 7) begin n_fail++; $display("FAIL flush_line_miss got miss=%b lat=%0d want 1/7", m, lat); end
    fetch(32'h8000_0010, inst, err, lat, h, m);
    n_cmp++; if (m !== 1'b1 || inst !== 32'h40DE_0010) begin n_fail++; $display("FAIL flush_old_miss got miss=%b inst=%h want 1/40de0010", m, inst); end
    flush = 1'b1;
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_flush_ready got %b want 0", req_ready); end
    flush = 1'b0;
    fetch(32'h8000_0034, inst, err, lat, h, m);
    n_cmp++; if (m !== 1'b1 || inst !== 32'h40DE_0034) begin n_fail++; $display("FAIL idle_flush_miss got miss=%b inst=%h want 1/40de0034", m, inst); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] inst; logic err, h, m; int lat, k;
    req_valid = 1'b1; req_addr = 32'h8000_0040; rsp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    k = 0;
    while (!mem_rready && k < 20) begin @(negedge clock); k++; end
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    $display("reset mid fill rready=%b arvalid=%b rsp_valid=%b req_ready=%b", mem_rready, mem_arvalid, rsp_valid, req_ready);
    n_cmp++; if ({mem_rready, mem_arvalid, rsp_valid, rsp_err, req_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL midreset_ctrl got %b want 00001", {mem_rready, mem_arvalid, rsp_valid, rsp_err, req_ready}); end
    n_cmp++; if (mem_araddr !== 32'h0 || rsp_inst !== 32'h0) begin
      n_fail++; $display("FAIL midreset_data got araddr=%h inst=%h want 0/0", mem_araddr, rsp_inst); end
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    fetch(32'h8000_0030, inst, err, lat, h, m);
    n_cmp++; if (m !== 1'b1 || lat !== 7 || inst !== 32'h40DE_0030) begin
      n_fail++; $display("FAIL post_reset_miss got miss=%b lat=%0d inst=%h want 1/7/40de0030", m, lat, inst); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_eviction();
    test_back_to_back();
    test_error();
    test_flush();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
